div_op_sequencer: RTL and testbench

Control and sign-handling stage that sits directly upstream and downstream of the team's unsigned pipelined divider. It accepts RISC-V M-extension divide requests (DIV, DIVU, REM, REMU) from the execute stage and converts signed operands to magnitudes. It drives the unsigned divider, carries per-op metadata alongside the divider pipeline, then applies sign correction and the RISC-V special cases. It also exposes a pending-destination mask so decode can stall on divide results still in flight.

---
 rtl/div_op_sequencer.sv | 142 ++++++++++++++
 tb/tb_div_op_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_op_sequencer.sv
// div_op_sequencer: sign handling and RISC-V special cases around the unsigned
// pipelined divider, plus the in-flight destination mask used by decode stalls.
module div_op_sequencer #(
  parameter int unsigned DIV_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic [4:0]  i_tag,
  output logic [31:0] o_div_dividend,
  output logic [31:0] o_div_divisor,
  input  logic [31:0] i_div_quotient,
  input  logic [31:0] i_div_remainder,
  output logic        o_valid,
  output logic [31:0] o_result,
  output logic [4:0]  o_tag,
  output logic [31:0] o_pending
);

  // Metadata slot that travels alongside the divider pipeline
  typedef struct packed {
    logic        valid;
    logic        neg_q;
    logic        neg_r;
    logic        is_rem;
    logic        div_zero;
    logic [31:0] rs1;
    logic [4:0]  tag;
  } meta_t;

  localparam int unsigned DEPTH = DIV_LATENCY + 1;

  logic        accept;
  logic        is_signed;
  logic [31:0] mag_rs1;
  logic [31:0] mag_rs2;
  meta_t       meta_in;
  meta_t       meta_q [DEPTH];
  meta_t       meta_out;

  logic [31:0] dividend_q;
  logic [31:0] divisor_q;
  logic        valid_q,  valid_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  tag_q,    tag_d;
  logic [31:0] pending_q, pending_d;

  // o_ready only looks at the registered mask, so there is no i_valid -> o_ready path
  assign o_ready        = !pending_q[i_tag];
  assign accept         = i_valid && o_ready;
  assign o_div_dividend = dividend_q;
  assign o_div_divisor  = divisor_q;
  assign o_valid        = valid_q;
  assign o_result       = result_q;
  assign o_tag          = tag_q;
  assign o_pending      = pending_q;
  assign meta_out       = meta_q[DEPTH-1];

  // Stage A: operand magnitudes and per-op metadata (|0x80000000| wraps to itself)
  always_comb begin
    is_signed        = !i_op[0];
    mag_rs1          = (is_signed && i_rs1[31]) ? (~i_rs1 + 32'd1) : i_rs1;
    mag_rs2          = (is_signed && i_rs2[31]) ? (~i_rs2 + 32'd1) : i_rs2;
    meta_in          = '0;
    meta_in.valid    = accept;
    meta_in.neg_q    = is_signed && (i_rs1[31] ^ i_rs2[31]);
    meta_in.neg_r    = is_signed && i_rs1[31];
    meta_in.is_rem   = i_op[1];
    meta_in.div_zero = (i_rs2 == 32'd0);
    meta_in.rs1      = i_rs1;
    meta_in.tag      = i_tag;
  end

  // Divider operand registers, held until the next accepted op
  always_ff @(posedge clk) begin
    if (rst) begin
      dividend_q <= '0;
      divisor_q  <= '0;
    end else if (accept) begin
      dividend_q <= mag_rs1;
      divisor_q  <= mag_rs2;
    end
  end

  // Metadata shift pipeline; the last slot lines up with the divider results
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) meta_q[i] <= '0;
    end else begin
      meta_q[0] <= meta_in;
      for (int i = 1; i < int'(DEPTH); i++) meta_q[i] <= meta_q[i-1];
    end
  end

  // Stage C: sign correction and divide-by-zero results
  always_comb begin
    valid_d  = meta_out.valid;
    tag_d    = tag_q;
    result_d = result_q;
    if (meta_out.valid) begin
      tag_d = meta_out.tag;
      if (meta_out.div_zero)
        result_d = meta_out.is_rem ? meta_out.rs1 : 32'hFFFF_FFFF;
      else if (meta_out.is_rem)
        result_d = meta_out.neg_r ? (~i_div_remainder + 32'd1) : i_div_remainder;
      else
        result_d = meta_out.neg_q ? (~i_div_quotient + 32'd1) : i_div_quotient;
    end
  end

  // Output result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      tag_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      tag_q    <= tag_d;
    end
  end

  // Pending mask: clear on the retire cycle's edge, set on accept; x0 never tracked
  always_comb begin
    pending_d = pending_q;
    if (valid_q) pending_d[tag_q] = 1'b0;
    if (accept)  pending_d[i_tag] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Pending mask register
  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

endmodule

// File: tb/tb_div_op_sequencer.sv
// Bench for div_op_sequencer: behavioural unsigned divider, scoreboard of expected
// results with retire cycle, pending mask derived from the scoreboard contents.
module tb_div_op_sequencer;
  localparam int unsigned LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [1:0]  i_op = '0;
  logic [31:0] i_rs1 = '0;
  logic [31:0] i_rs2 = '0;
  logic [4:0]  i_tag = '0;
  logic [31:0] o_div_dividend, o_div_divisor;
  logic [31:0] q_m, r_m;
  logic        o_valid;
  logic [31:0] o_result;
  logic [4:0]  o_tag;
  logic [31:0] o_pending;

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  div_op_sequencer #(.DIV_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_tag(i_tag),
    .o_div_dividend(o_div_dividend), .o_div_divisor(o_div_divisor),
    .i_div_quotient(q_m), .i_div_remainder(r_m),
    .o_valid(o_valid), .o_result(o_result), .o_tag(o_tag), .o_pending(o_pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Unsigned divider with one cycle of latency
  always @(posedge clk) begin
    if (o_div_divisor == 32'd0) begin
      q_m <= 32'hFFFF_FFFF;
      r_m <= o_div_dividend;
    end else begin
      q_m <= o_div_dividend / o_div_divisor;
      r_m <= o_div_dividend % o_div_divisor;
    end
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sb_;
    sa = a;
    sb_ = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      2'd0: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb_);
      2'd1: return a / b;
      2'd2: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb_);
      default: return a % b;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after acceptance
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp, output int waits);
    exp_t e;
    i_valid = 1'b1;
    i_op    = op;
    i_rs1   = a;
    i_rs2   = b;
    i_tag   = tag;
    waits   = 0;
    #1;
    while (!o_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!o_ready) begin
      chk("issue_timeout", {31'd0, o_ready}, 32'd1);
      i_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.tag = tag;
    e.res = exp;
    e.due = cyc + int'(LAT) + 2;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    i_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: retire order/value/latency and pending mask against scoreboard
  always @(negedge clk) begin : mon
    logic [31:0] exp_p;
    exp_t e;
    if (rst === 1'b0) begin
      exp_p = '0;
      foreach (sb[i]) exp_p[sb[i].tag] = 1'b1;
      exp_p[0] = 1'b0;
      chk("pending_mask", o_pending, exp_p);
      if (o_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", {31'd0, o_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result", o_result, e.res);
          chk("tag", {27'd0, o_tag}, {27'd0, e.tag});
          chk("latency_cycle", cyc, e.due);
        end
      end
    end
  end

  initial begin
    int w;
    int w2;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_result", o_result, 32'd0);
    chk("rst_tag", {27'd0, o_tag}, 32'd0);
    chk("rst_pending", o_pending, 32'd0);
    chk("rst_dividend", o_div_dividend, 32'd0);
    chk("rst_divisor", o_div_divisor, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed sign / divide-by-zero / overflow cases, back-to-back
    issue(2'd0, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, w);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, w);
    issue(2'd1, 32'd7, 32'd0, 5'd7, 32'hFFFF_FFFF, w);
    issue(2'd2, 32'h8000_0005, 32'd0, 5'd8, 32'h8000_0005, w);
    issue(2'd0, 32'hFFFF_FFF9, 32'd0, 5'd10, 32'hFFFF_FFFF, w);
    issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, w);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, w);
    issue(2'd3, 32'h8000_0000, 32'd3, 5'd13, 32'd2, w);
    issue(2'd1, 32'hFFFF_FFF9, 32'd2, 5'd14, 32'h7FFF_FFFC, w);
    drain();

    // Four back-to-back ops to distinct tags: no stalls
    issue(2'd0, 32'd100, 32'd7, 5'd1, 32'd14, w);
    chk("b2b_wait1", w, 32'd0);
    issue(2'd2, 32'hFFFF_FF9C, 32'd7, 5'd2, 32'hFFFF_FFFE, w);
    chk("b2b_wait2", w, 32'd0);
    issue(2'd0, 32'd100, 32'hFFFF_FFF9, 5'd3, 32'hFFFF_FFF2, w);
    chk("b2b_wait3", w, 32'd0);
    issue(2'd3, 32'd100, 32'd7, 5'd4, 32'd2, w);
    chk("b2b_wait4", w, 32'd0);
    drain();

    // Same rd twice: second waits for the first to retire
    issue(2'd1, 32'd50, 32'd5, 5'd9, 32'd10, w);
    issue(2'd3, 32'd50, 32'd7, 5'd9, 32'd1, w2);
    chk("same_tag_stall", w2, 32'd3);
    drain();

    // x0 never blocks
    issue(2'd0, 32'd9, 32'd3, 5'd0, 32'd3, w);
    issue(2'd2, 32'd9, 32'd4, 5'd0, 32'd1, w);
    chk("tag0_no_stall", w, 32'd0);
    drain();

    // Random mix checked against the reference model
    for (int k = 0; k < 24; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      if (k == 0) ra = 32'h8000_0000;
      issue(rop, ra, rb, 5'($urandom_range(0, 31)), ref_div(rop, ra, rb), w);
    end
    drain();

    // Reset with two ops in flight: both are discarded
    issue(2'd0, 32'd20, 32'd3, 5'd6, 32'd6, w);
    issue(2'd2, 32'd20, 32'd3, 5'd7, 32'd2, w);
    i_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("flush_pending", o_pending, 32'd0);
    i_tag = 5'd6;
    #1;
    chk("flush_ready6", {31'd0, o_ready}, 32'd1);
    i_tag = 5'd7;
    #1;
    chk("flush_ready7", {31'd0, o_ready}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("flush_no_valid", {31'd0, o_valid}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
